junction_route_setter: RTL and testbench

- Downstream consumer of the train traffic controller's 3-bit grant code.
- Per grant: drives the points machine to the granted route, waits for lock, clears that approach's signal, tracks the train through the crossing, then returns a 1-cycle train_done pulse to the controller.
- Any loss or change of grant before the train enters aborts to all-red.
- Points lock timeout and invalid grant codes raise a sticky fault.

---
 rtl/junction_route_setter_if.sv | 26 ++
 rtl/junction_route_setter.sv | 191 +++++++++++++++++++
 tb/tb_junction_route_setter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/junction_route_setter_if.sv
// Signal bundle between the traffic controller / trackside equipment and
// junction_route_setter.
interface junction_route_setter_if;
  logic [2:0] grant;
  logic       points_locked;
  logic       entry_sensor;
  logic       exit_sensor;
  logic       fault_clr;
  logic [1:0] points_cmd;
  logic       points_move;
  logic [3:0] sig_green;
  logic [3:0] sig_amber;
  logic       train_done;
  logic       busy;
  logic       fault;

  modport master (
    output grant, points_locked, entry_sensor, exit_sensor, fault_clr,
    input  points_cmd, points_move, sig_green, sig_amber, train_done, busy, fault
  );

  modport slave (
    input  grant, points_locked, entry_sensor, exit_sensor, fault_clr,
    output points_cmd, points_move, sig_green, sig_amber, train_done, busy, fault
  );
endinterface

// File: rtl/junction_route_setter.sv
// Junction route setter: sets points for a granted route, clears the signal,
// tracks the train across the crossing and reports train_done.
// Optional caution aspect after entry is enabled by defining ROUTE_AMBER_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for a valid grant (ignored while fault is set)
// SET_POINTS | points motor driven, waiting for points_locked or timeout
// CLEAR      | proceed aspect shown, waiting for the train to pass signal
// OCCUPIED   | train committed to the crossing, waiting for exit_sensor
// RELEASE    | exit seen, holding CLEAR_HOLD cycles before release
// DONE       | single-cycle train_done pulse
module junction_route_setter #(
  parameter int SETTLE_MAX   = 8,
  parameter int CLEAR_HOLD   = 3,
  parameter int AMBER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  junction_route_setter_if.slave jif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SET_POINTS = 3'd1,
    CLEAR      = 3'd2,
    OCCUPIED   = 3'd3,
    RELEASE    = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_MAX - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(CLEAR_HOLD - 1);

  if (SETTLE_MAX < 2 || SETTLE_MAX > 255) begin : g_bad_settle
    $error("SETTLE_MAX outside 2..255");
  end
  if (CLEAR_HOLD < 1 || CLEAR_HOLD > 255) begin : g_bad_hold
    $error("CLEAR_HOLD outside 1..255");
  end
  if (AMBER_CYCLES < 1 || AMBER_CYCLES > 255) begin : g_bad_amber
    $error("AMBER_CYCLES outside 1..255");
  end

`ifdef ROUTE_AMBER_EN
  localparam logic [7:0] AMBER_LAST = 8'(AMBER_CYCLES - 1);
`endif

  state_t     state_q, state_nxt;
  logic [2:0] route_q, route_nxt;
  logic [7:0] timer_q, timer_nxt;
  logic [1:0] cmd_q, cmd_nxt;
  logic       move_q, move_nxt;
  logic [3:0] green_q, green_nxt;
  logic [3:0] amber_q, amber_nxt;
  logic       done_q, done_nxt;
  logic       busy_q, busy_nxt;
  logic       fault_q, fault_nxt;
  logic [7:0] timer_inc;
  logic       grant_valid;
  logic       grant_lost;

  assign timer_inc   = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
  assign grant_valid = (jif.grant >= 3'd1) && (jif.grant <= 3'd4);
  assign grant_lost  = (jif.grant != route_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      route_q <= 3'd0;
      timer_q <= 8'd0;
      cmd_q   <= 2'd0;
      move_q  <= 1'b0;
      green_q <= 4'd0;
      amber_q <= 4'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      route_q <= route_nxt;
      timer_q <= timer_nxt;
      cmd_q   <= cmd_nxt;
      move_q  <= move_nxt;
      green_q <= green_nxt;
      amber_q <= amber_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
      fault_q <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    route_nxt = route_q;
    timer_nxt = timer_q;
    cmd_nxt   = cmd_q;
    move_nxt  = move_q;
    green_nxt = green_q;
    amber_nxt = amber_q;
    fault_nxt = fault_q;

    case (state_q)
      IDLE: begin
        if (fault_q) begin
          if (jif.fault_clr) fault_nxt = 1'b0;
        end else if (grant_valid) begin
          route_nxt = jif.grant;
          cmd_nxt   = 2'(jif.grant - 3'd1);
          move_nxt  = 1'b1;
          timer_nxt = 8'd0;
          state_nxt = SET_POINTS;
        end else if (jif.grant != 3'd0) begin
          fault_nxt = 1'b1;
        end
      end

      SET_POINTS: begin
        if (grant_lost) begin
          move_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (jif.points_locked) begin
          move_nxt  = 1'b0;
          green_nxt = 4'b0001 << cmd_q;
          state_nxt = CLEAR;
        end else if (timer_q == SETTLE_LAST) begin
          move_nxt  = 1'b0;
          fault_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      CLEAR: begin
        // Once the train is past the signal it cannot be stopped, so entry
        // wins over a simultaneous grant withdrawal.
        if (jif.entry_sensor) begin
          green_nxt = 4'd0;
          state_nxt = OCCUPIED;
`ifdef ROUTE_AMBER_EN
          amber_nxt = 4'b0001 << cmd_q;
          timer_nxt = 8'd0;
`endif
        end else if (grant_lost) begin
          green_nxt = 4'd0;
          state_nxt = IDLE;
        end
      end

      OCCUPIED: begin
        if (jif.exit_sensor) begin
          amber_nxt = 4'd0;
          timer_nxt = 8'd0;
          state_nxt = RELEASE;
        end
`ifdef ROUTE_AMBER_EN
        else if (amber_q != 4'd0) begin
          if (timer_q == AMBER_LAST) amber_nxt = 4'd0;
          else                       timer_nxt = timer_inc;
        end
`endif
      end

      RELEASE: begin
        if (timer_q == HOLD_LAST) state_nxt = DONE;
        else                      timer_nxt = timer_inc;
      end

      // The grant seen here is stale; it is re-sampled from IDLE.
      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase

`ifndef ROUTE_AMBER_EN
    amber_nxt = 4'd0;
`endif
    done_nxt = (state_nxt == DONE);
    busy_nxt = (state_nxt != IDLE);
  end

  assign jif.points_cmd  = cmd_q;
  assign jif.points_move = move_q;
  assign jif.sig_green   = green_q;
  assign jif.sig_amber   = amber_q;
  assign jif.train_done  = done_q;
  assign jif.busy        = busy_q;
  assign jif.fault       = fault_q;

endmodule

// File: tb/tb_junction_route_setter.sv
// Self-checking bench for junction_route_setter: directed scenarios with
// literal expectations, then randomized traffic against a phase-level model.
module tb_junction_route_setter;
  localparam int SETTLE_MAX   = 8;
  localparam int CLEAR_HOLD   = 3;
  localparam int AMBER_CYCLES = 2;

  localparam int P_IDLE = 0, P_SET = 1, P_CLEAR = 2, P_OCC = 3, P_REL = 4, P_DONE = 5;

`ifdef ROUTE_AMBER_EN
  localparam int AMBER_ON = 1;
`else
  localparam int AMBER_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  junction_route_setter_if jif ();

  junction_route_setter #(
    .SETTLE_MAX  (SETTLE_MAX),
    .CLEAR_HOLD  (CLEAR_HOLD),
    .AMBER_CYCLES(AMBER_CYCLES)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .jif    (jif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: where the train/route is, and what that implies.
  int m_phase = P_IDLE;
  int m_code  = 0;
  int m_route = 0;
  int m_cnt   = 0;
  int m_fault = 0;
  int m_amber_left = 0;

  always @(posedge clk or negedge reset_n) begin
    int g;
    if (!reset_n) begin
      m_phase = P_IDLE; m_code = 0; m_route = 0; m_cnt = 0;
      m_fault = 0; m_amber_left = 0;
    end else begin
      g = int'(jif.grant);
      case (m_phase)
        P_IDLE: begin
          if (m_fault != 0) begin
            if (jif.fault_clr) m_fault = 0;
          end else if (g >= 1 && g <= 4) begin
            m_code = g; m_route = g - 1; m_cnt = 0; m_phase = P_SET;
          end else if (g >= 5) begin
            m_fault = 1;
          end
        end
        P_SET: begin
          if (g != m_code) m_phase = P_IDLE;
          else if (jif.points_locked) m_phase = P_CLEAR;
          else if (m_cnt == SETTLE_MAX - 1) begin m_fault = 1; m_phase = P_IDLE; end
          else m_cnt++;
        end
        P_CLEAR: begin
          if (jif.entry_sensor) begin
            m_phase = P_OCC;
            if (AMBER_ON != 0) m_amber_left = AMBER_CYCLES;
          end else if (g != m_code) m_phase = P_IDLE;
        end
        P_OCC: begin
          if (jif.exit_sensor) begin m_phase = P_REL; m_cnt = 0; m_amber_left = 0; end
          else if (m_amber_left > 0) m_amber_left--;
        end
        P_REL: begin
          m_cnt++;
          if (m_cnt == CLEAR_HOLD) m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [1:0] e_cmd;
    logic       e_move, e_done, e_busy, e_fault;
    logic [3:0] e_green, e_amber;
    if (reset_n) begin
      e_cmd   = 2'(m_route);
      e_move  = (m_phase == P_SET);
      e_green = (m_phase == P_CLEAR) ? 4'(1 << m_route) : 4'd0;
      e_amber = (m_amber_left > 0) ? 4'(1 << m_route) : 4'd0;
      e_done  = (m_phase == P_DONE);
      e_busy  = (m_phase != P_IDLE);
      e_fault = (m_fault != 0);
      n_tests++;
      if (jif.points_cmd !== e_cmd || jif.points_move !== e_move ||
          jif.sig_green !== e_green || jif.sig_amber !== e_amber ||
          jif.train_done !== e_done || jif.busy !== e_busy || jif.fault !== e_fault) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got cmd=%0d mv=%0b g=%b a=%b d=%0b b=%0b f=%0b exp cmd=%0d mv=%0b g=%b a=%b d=%0b b=%0b f=%0b",
                 $time, jif.points_cmd, jif.points_move, jif.sig_green, jif.sig_amber,
                 jif.train_done, jif.busy, jif.fault,
                 e_cmd, e_move, e_green, e_amber, e_done, e_busy, e_fault);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cmd"},   8'(jif.points_cmd),  8'd0);
    chk({name, "_move"},  8'(jif.points_move), 8'd0);
    chk({name, "_green"}, 8'(jif.sig_green),   8'd0);
    chk({name, "_amber"}, 8'(jif.sig_amber),   8'd0);
    chk({name, "_done"},  8'(jif.train_done),  8'd0);
    chk({name, "_busy"},  8'(jif.busy),        8'd0);
    chk({name, "_fault"}, 8'(jif.fault),       8'd0);
  endtask

  initial begin
    jif.grant = 3'd0; jif.points_locked = 1'b0; jif.entry_sensor = 1'b0;
    jif.exit_sensor = 1'b0; jif.fault_clr = 1'b0;
    #1 reset_n = 1'b0;
    #11 chk_all_zero("reset");
    #11 reset_n = 1'b1;
    @(negedge clk);

    // Normal run on T1
    jif.grant = 3'd1;
    cyc(1);
    chk("norm_move", 8'(jif.points_move), 8'd1);
    chk("norm_busy", 8'(jif.busy), 8'd1);
    chk("norm_cmd", 8'(jif.points_cmd), 8'd0);
    chk("norm_green_pre", 8'(jif.sig_green), 8'd0);
    cyc(2);
    jif.points_locked = 1'b1;
    cyc(1);
    chk("norm_green", 8'(jif.sig_green), 8'b0001);
    chk("norm_move_off", 8'(jif.points_move), 8'd0);
    jif.points_locked = 1'b0;
    cyc(2);
    chk("norm_green_hold", 8'(jif.sig_green), 8'b0001);
    jif.entry_sensor = 1'b1;
    cyc(1);
    jif.entry_sensor = 1'b0;
    chk("norm_green_entry", 8'(jif.sig_green), 8'd0);
    chk("norm_amber_entry", 8'(jif.sig_amber), 8'(AMBER_ON));
    cyc(2);
    jif.exit_sensor = 1'b1;
    cyc(1);
    jif.exit_sensor = 1'b0;
    cyc(CLEAR_HOLD - 1);
    chk("norm_done_early", 8'(jif.train_done), 8'd0);
    cyc(1);
    chk("norm_done", 8'(jif.train_done), 8'd1);
    chk("norm_cmd_done", 8'(jif.points_cmd), 8'd0);
    jif.grant = 3'd0;
    cyc(1);
    chk("norm_done_off", 8'(jif.train_done), 8'd0);
    chk("norm_busy_off", 8'(jif.busy), 8'd0);

    // Lock timeout on T3
    jif.grant = 3'd3;
    cyc(1);
    chk("tmo_cmd", 8'(jif.points_cmd), 8'd2);
    cyc(SETTLE_MAX - 1);
    chk("tmo_move_last", 8'(jif.points_move), 8'd1);
    chk("tmo_fault_pre", 8'(jif.fault), 8'd0);
    cyc(1);
    chk("tmo_move_off", 8'(jif.points_move), 8'd0);
    chk("tmo_fault", 8'(jif.fault), 8'd1);
    jif.grant = 3'd2;
    cyc(2);
    chk("tmo_ignored", 8'(jif.busy), 8'd0);
    jif.fault_clr = 1'b1;
    cyc(1);
    jif.fault_clr = 1'b0;
    chk("tmo_cleared", 8'(jif.fault), 8'd0);
    cyc(1);
    chk("tmo_regrant_busy", 8'(jif.busy), 8'd1);
    chk("tmo_regrant_cmd", 8'(jif.points_cmd), 8'd1);
    jif.grant = 3'd0;
    cyc(1);

    // Abort on T4 before entry
    jif.grant = 3'd4;
    cyc(1);
    jif.points_locked = 1'b1;
    cyc(1);
    jif.points_locked = 1'b0;
    chk("abort_green", 8'(jif.sig_green), 8'b1000);
    jif.grant = 3'd0;
    cyc(1);
    chk("abort_green_off", 8'(jif.sig_green), 8'd0);
    chk("abort_busy", 8'(jif.busy), 8'd0);
    cyc(3);

    // Committed: grant withdrawn while occupied
    jif.grant = 3'd2;
    cyc(1);
    jif.points_locked = 1'b1;
    cyc(1);
    jif.points_locked = 1'b0;
    jif.entry_sensor = 1'b1;
    cyc(1);
    jif.entry_sensor = 1'b0;
    jif.grant = 3'd0;
    cyc(3);
    chk("commit_busy", 8'(jif.busy), 8'd1);
    jif.exit_sensor = 1'b1;
    cyc(1);
    jif.exit_sensor = 1'b0;
    cyc(CLEAR_HOLD);
    chk("commit_done", 8'(jif.train_done), 8'd1);
    cyc(1);

    // Back-to-back: grant held across DONE
    jif.grant = 3'd1;
    cyc(1);
    jif.points_locked = 1'b1;
    cyc(1);
    jif.points_locked = 1'b0;
    jif.entry_sensor = 1'b1;
    cyc(1);
    jif.entry_sensor = 1'b0;
    jif.exit_sensor = 1'b1;
    cyc(1);
    jif.exit_sensor = 1'b0;
    cyc(CLEAR_HOLD);
    chk("b2b_done", 8'(jif.train_done), 8'd1);
    cyc(1);
    chk("b2b_no_retrig", 8'(jif.busy), 8'd0);
    cyc(1);
    chk("b2b_retrig", 8'(jif.points_move), 8'd1);
    jif.grant = 3'd0;
    cyc(1);

    // Invalid grant and fault_clr interactions
    jif.grant = 3'd6;
    cyc(1);
    chk("inv_fault", 8'(jif.fault), 8'd1);
    jif.fault_clr = 1'b1;
    cyc(1);
    jif.fault_clr = 1'b0;
    chk("inv_clr", 8'(jif.fault), 8'd0);
    cyc(1);
    chk("inv_reraise", 8'(jif.fault), 8'd1);
    jif.grant = 3'd0; jif.fault_clr = 1'b1;
    cyc(1);
    jif.grant = 3'd5;
    cyc(1);
    chk("inv_set_wins", 8'(jif.fault), 8'd1);
    jif.grant = 3'd0;
    cyc(1);
    jif.fault_clr = 1'b0;
    chk("inv_final_clr", 8'(jif.fault), 8'd0);

    // Async reset while in CLEAR
    jif.grant = 3'd1;
    cyc(1);
    jif.points_locked = 1'b1;
    cyc(1);
    jif.points_locked = 1'b0;
    chk("arst_green_pre", 8'(jif.sig_green), 8'b0001);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("arst");
    jif.grant = 3'd0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 19) < 2) jif.grant = 3'($urandom_range(5, 7));
        else                           jif.grant = 3'($urandom_range(0, 4));
      end
      jif.points_locked = ($urandom_range(0, 3) == 0);
      jif.entry_sensor  = ($urandom_range(0, 3) == 0);
      jif.exit_sensor   = ($urandom_range(0, 3) == 0);
      jif.fault_clr     = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    jif.grant = 3'd0; jif.points_locked = 1'b0; jif.entry_sensor = 1'b0;
    jif.exit_sensor = 1'b1; jif.fault_clr = 1'b0;
    cyc(CLEAR_HOLD + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
